// File: rtl/ac97_pcm_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ac97_pcm_feeder_pkg
// Description : Shared constants and helpers for the AC-97 PCM playback path.
//               Slot geometry matches the s6ac97 / genac97 controller: a
//               20-bit slot carrying a 16-bit MSB-aligned PCM sample.
// Revision    : 1.0 - initial release
// ============================================================================
package ac97_pcm_feeder_pkg;

    // AC-97 PCM slot geometry
    localparam int AC97_SLOT_W = 20;
    localparam int AC97_PCM_W  = 16;
    localparam int AC97_PAD    = AC97_SLOT_W - AC97_PCM_W;

    // Ceiling of the underrun event counter
    localparam logic [15:0] C_UNDERRUN_MAX = 16'hFFFF;

    // Increment that sticks at the ceiling instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == C_UNDERRUN_MAX) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ac97_pcm_feeder_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ac97_pcm_feeder_sync_fifo
// Description : Single-clock FIFO with level counter. Full/empty derive from
//               the level, so pointers simply wrap modulo DEPTH.
//               Push on a full FIFO and pop on an empty FIFO are ignored.
//               i_flush behaves like a reset of the pointers and level.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               i_flush      - synchronous flush (pointers/level to 0)
//               i_push/i_wdata, i_pop/o_rdata (first-word fall-through read)
//               o_full, o_empty, o_level
// Revision    : 1.0 - initial release
// ============================================================================
module ac97_pcm_feeder_sync_fifo #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_pop,
    output logic [WIDTH-1:0]  o_rdata,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_level
);

    localparam logic [ADDR_W:0]   c_full_lvl = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_lvl_one  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one  = ADDR_W'(1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_level == c_full_lvl);
    assign w_empty   = (r_level == '0);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; only pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !rst && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/ac97_pcm_feeder.sv
`default_nettype none
// ============================================================================
// Module      : ac97_pcm_feeder
// Description : Stereo PCM buffer feeding the s6ac97 DAC slot inputs. Pairs
//               arrive over valid/ready, are buffered in a FIFO and exactly
//               one pair is released per AC-97 frame, paced by the
//               controller's ready pulse. An empty FIFO at frame time emits
//               silence and is recorded as an underrun.
// Ports       : CCLK, rst               - clock, sync active-high reset
//               en                      - playback enable
//               s_valid/s_ready/s_left/s_right - upstream sample pairs
//               ready                   - s6ac97 frame pulse (asynchronous)
//               leftdac/rightdac, left_vd/right_vd - slot data to s6ac97
//               fifo_level              - pairs currently buffered
//               underrun/underrun_cnt/underrun_clr - underrun reporting
// Revision    : 1.0 - initial release
// ============================================================================
module ac97_pcm_feeder
    import ac97_pcm_feeder_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int PCM_W  = AC97_PCM_W
) (
    input  logic                   CCLK,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [PCM_W-1:0]       s_left,
    input  logic [PCM_W-1:0]       s_right,
    input  logic                   ready,
    output logic [AC97_SLOT_W-1:0] leftdac,
    output logic [AC97_SLOT_W-1:0] rightdac,
    output logic                   left_vd,
    output logic                   right_vd,
    output logic [ADDR_W:0]        fifo_level,
    output logic                   underrun,
    input  logic                   underrun_clr,
    output logic [15:0]            underrun_cnt
);

    // Ready synchronizer and edge detector
    logic r_rdy_meta;
    logic r_rdy_sync;
    logic r_rdy_prev;
    logic r_frame_req;
    logic w_frame_edge;

    // Output and status registers
    logic [AC97_SLOT_W-1:0] r_leftdac;
    logic [AC97_SLOT_W-1:0] r_rightdac;
    logic                   r_vd;
    logic                   r_underrun;
    logic [15:0]            r_underrun_cnt;
    logic                   r_priming;

    // FIFO interface
    logic [2*PCM_W-1:0] w_rdata;
    logic [PCM_W-1:0]   w_left;
    logic [PCM_W-1:0]   w_right;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    // Rising edge of the synchronized level; a long ready level gives one pulse.
    assign w_frame_edge = r_rdy_sync && !r_rdy_prev;

    // s_ready depends only on enable, reset and registered FIFO state.
    assign s_ready = en && !rst && !w_full;
    assign w_push  = s_valid && s_ready;
    assign w_pop   = r_frame_req && en;

    assign w_left  = w_rdata[2*PCM_W-1 -: PCM_W];
    assign w_right = w_rdata[PCM_W-1:0];

    ac97_pcm_feeder_sync_fifo #(
        .WIDTH  (2*PCM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (CCLK),
        .rst     (rst),
        .i_flush (!en),
        .i_push  (w_push),
        .i_wdata ({s_left, s_right}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    always_ff @(posedge CCLK) begin
        if (rst) begin
            r_rdy_meta     <= 1'b0;
            r_rdy_sync     <= 1'b0;
            r_rdy_prev     <= 1'b0;
            r_frame_req    <= 1'b0;
            r_leftdac      <= '0;
            r_rightdac     <= '0;
            r_vd           <= 1'b0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
            r_priming      <= 1'b1;
        end else begin
            r_rdy_meta  <= ready;
            r_rdy_sync  <= r_rdy_meta;
            r_rdy_prev  <= r_rdy_sync;
            r_frame_req <= w_frame_edge;

            if (!en) begin
                // Playback stopped: silence, slots invalid, re-arm priming.
                r_leftdac  <= '0;
                r_rightdac <= '0;
                r_vd       <= 1'b0;
                r_priming  <= 1'b1;
            end else if (r_frame_req) begin
                r_vd <= 1'b1;
                if (!w_empty) begin
                    r_leftdac  <= {w_left,  {AC97_PAD{1'b0}}};
                    r_rightdac <= {w_right, {AC97_PAD{1'b0}}};
                    r_priming  <= 1'b0;
                end else begin
                    // A pair pushed this same cycle is not forwarded; it
                    // waits for the next frame.
                    r_leftdac  <= '0;
                    r_rightdac <= '0;
                    if (!r_priming) begin
                        r_underrun     <= 1'b1;
                        r_underrun_cnt <= sat_inc16(r_underrun_cnt);
                    end
                end
            end

            // Placed last so a clear overrides a same-cycle increment.
            if (underrun_clr) begin
                r_underrun     <= 1'b0;
                r_underrun_cnt <= '0;
            end
        end
    end

    assign leftdac      = r_leftdac;
    assign rightdac     = r_rightdac;
    assign left_vd      = r_vd;
    assign right_vd     = r_vd;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_underrun_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ac97_pcm_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ac97_pcm_feeder
// Description : Self-checking bench for ac97_pcm_feeder. A reference model
//               keeps the buffered pairs in a queue and predicts the state
//               after every clock edge; a monitor compares the DUT against
//               those predictions. Directed scenarios are followed by a
//               randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ac97_pcm_feeder;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int PCM_W  = 16;

    logic              CCLK = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [PCM_W-1:0]  s_left = '0;
    logic [PCM_W-1:0]  s_right = '0;
    logic              ready = 1'b0;
    logic [19:0]       leftdac;
    logic [19:0]       rightdac;
    logic              left_vd;
    logic              right_vd;
    logic [ADDR_W:0]   fifo_level;
    logic              underrun;
    logic              underrun_clr = 1'b0;
    logic [15:0]       underrun_cnt;

    ac97_pcm_feeder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .PCM_W  (PCM_W)
    ) dut (
        .CCLK         (CCLK),
        .rst          (rst),
        .en           (en),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_left       (s_left),
        .s_right      (s_right),
        .ready        (ready),
        .leftdac      (leftdac),
        .rightdac     (rightdac),
        .left_vd      (left_vd),
        .right_vd     (right_vd),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .underrun_cnt (underrun_cnt)
    );

    always #5 CCLK = ~CCLK;

    // Number of rising edges seen so far
    int cyc = 0;
    always @(posedge CCLK) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [19:0] l;
        logic [19:0] r;
        logic        vd;
        logic        ur;
        logic [15:0] cnt;
        int          lvl;
    } exp_t;

    exp_t        sb[$];      // predicted state, one entry per edge
    logic [31:0] mq[$];      // model of the buffered pairs
    int          due_q[$];   // edges at which a frame pop is expected

    logic [19:0] m_l = '0;
    logic [19:0] m_r = '0;
    logic        m_vd = 1'b0;
    logic        m_ur = 1'b0;
    logic        m_prime = 1'b1;
    logic [15:0] m_cnt = '0;

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------------
    // Reference model: runs mid-cycle, predicts the state after the next edge
    // ------------------------------------------------------------------
    always @(negedge CCLK) begin : p_predict
        bit          pop_now;
        bit          acc;
        logic [31:0] p;
        exp_t        e;
        pop_now = 1'b0;
        while (due_q.size() > 0 && due_q[0] <= cyc + 1) begin
            if (due_q[0] == cyc + 1) pop_now = 1'b1;
            due_q.delete(0);
        end
        if (rst) begin
            mq.delete();
            due_q.delete();
            m_l = '0; m_r = '0; m_vd = 1'b0; m_ur = 1'b0; m_cnt = '0; m_prime = 1'b1;
        end else begin
            acc = en && s_valid && (mq.size() < DEPTH);
            if (!en) begin
                mq.delete();
                m_l = '0; m_r = '0; m_vd = 1'b0; m_prime = 1'b1;
            end else if (pop_now) begin
                m_vd = 1'b1;
                if (mq.size() > 0) begin
                    p = mq.pop_front();
                    m_l = {p[31:16], 4'h0};
                    m_r = {p[15:0], 4'h0};
                    m_prime = 1'b0;
                end else begin
                    m_l = '0; m_r = '0;
                    if (!m_prime) begin
                        m_ur = 1'b1;
                        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    end
                end
            end
            if (acc) mq.push_back({s_left, s_right});
            if (underrun_clr) begin
                m_ur = 1'b0; m_cnt = '0;
            end
        end
        e.due = cyc + 1; e.l = m_l; e.r = m_r; e.vd = m_vd;
        e.ur = m_ur; e.cnt = m_cnt; e.lvl = mq.size();
        sb.push_back(e);
    end

    // ------------------------------------------------------------------
    // Monitor: compares the DUT against the prediction for this edge
    // ------------------------------------------------------------------
    always @(negedge CCLK) begin : p_monitor
        exp_t e;
        logic exp_rdy;
        while (sb.size() > 0 && sb[0].due < cyc) sb.delete(0);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            exp_rdy = en && !rst && (e.lvl != DEPTH);
            n_tests++;
            if ({leftdac, rightdac, left_vd, right_vd, underrun, underrun_cnt, fifo_level, s_ready} !==
                {e.l, e.r, e.vd, e.vd, e.ur, e.cnt, 5'(e.lvl), exp_rdy}) begin
                n_fail++;
                $display("FAIL state@%0d: got L=%h R=%h vd=%b%b ur=%b cnt=%0d lvl=%0d rdy=%b, expected L=%h R=%h vd=%b ur=%b cnt=%0d lvl=%0d rdy=%b",
                         cyc, leftdac, rightdac, left_vd, right_vd, underrun, underrun_cnt, fifo_level, s_ready,
                         e.l, e.r, e.vd, e.ur, e.cnt, e.lvl, exp_rdy);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 ns after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge CCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // A ready rise produces a pop on the 4th edge after it
    task automatic set_ready(input logic v);
        if (v && !ready) due_q.push_back(cyc + 4);
        ready = v;
    endtask

    task automatic pulse_ready(input int hi, input int lo);
        set_ready(1'b1);
        repeat (hi) tick();
        set_ready(1'b0);
        repeat (lo) tick();
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        int k;
        s_valid = 1'b1; s_left = l; s_right = r;
        k = 0;
        while (!s_ready && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) check("push_timeout", 32'(k), 32'd0);
        tick();
        s_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin : p_stim
        int k;
        int rcnt;
        repeat (3) tick();
        check("reset_leftdac", 32'(leftdac), 32'h0);
        check("reset_vd", 32'(left_vd), 32'h0);
        check("reset_level", 32'(fifo_level), 32'h0);
        check("reset_s_ready", 32'(s_ready), 32'h0);
        rst = 1'b0; en = 1'b1;
        tick();

        // Basic push and one frame pop
        push_pair(16'h1234, 16'hABCD);
        push_pair(16'h1111, 16'h2222);
        push_pair(16'h3333, 16'h4444);
        check("t1_level_before", 32'(fifo_level), 32'd3);
        pulse_ready(2, 6);
        check("t1_leftdac", 32'(leftdac), 32'h12340);
        check("t1_rightdac", 32'(rightdac), 32'hABCD0);
        check("t1_vd", 32'({left_vd, right_vd}), 32'h3);
        check("t1_level_after", 32'(fifo_level), 32'd2);

        // Long ready level pops once
        set_ready(1'b1);
        repeat (50) tick();
        set_ready(1'b0);
        repeat (6) tick();
        check("t2_level", 32'(fifo_level), 32'd1);
        check("t2_leftdac", 32'(leftdac), 32'h11110);

        // Fill to DEPTH, extra valid waits, pop lets one more in
        s_valid = 1'b1;
        k = 0;
        while (fifo_level != 5'(DEPTH) && k < 40) begin
            s_left = 16'($urandom); s_right = 16'($urandom);
            tick();
            k++;
        end
        repeat (3) tick();
        check("t3_full_level", 32'(fifo_level), 32'(DEPTH));
        check("t3_full_s_ready", 32'(s_ready), 32'h0);
        pulse_ready(2, 6);
        check("t3_refill_level", 32'(fifo_level), 32'(DEPTH));
        check("t3_leftdac", 32'(leftdac), 32'h33330);
        s_valid = 1'b0;

        // Drain, then underruns; clear coincident with 4th underrun frame
        k = 0;
        while (fifo_level != 0 && k < 40) begin
            pulse_ready(2, 4);
            k++;
        end
        repeat (3) pulse_ready(2, 4);
        check("t4_underrun", 32'(underrun), 32'h1);
        check("t4_cnt", 32'(underrun_cnt), 32'd3);
        check("t4_silence", 32'({leftdac, left_vd}), 32'h1);
        set_ready(1'b1);
        tick(); tick();
        set_ready(1'b0);
        tick();
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        tick();
        check("t4_cnt_cleared", 32'(underrun_cnt), 32'd0);
        check("t4_underrun_cleared", 32'(underrun), 32'h0);

        // Priming: first empty frame after enable is not an underrun
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        tick();
        pulse_ready(2, 6);
        check("t5_priming_underrun", 32'(underrun), 32'h0);
        check("t5_priming_vd", 32'(left_vd), 32'h1);

        // Reset between ready edge and frame request
        push_pair(16'h5555, 16'h6666);
        push_pair(16'h7777, 16'h8888);
        set_ready(1'b1);
        tick(); tick();
        rst = 1'b1; ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        repeat (6) tick();
        check("t6_rst_level", 32'(fifo_level), 32'd0);
        check("t6_rst_out", 32'({leftdac, rightdac, left_vd}), 32'h0);

        // Enable dropped mid-stream
        push_pair(16'h9999, 16'hAAAA);
        push_pair(16'hBBBB, 16'hCCCC);
        pulse_ready(2, 6);
        en = 1'b0;
        tick(); tick();
        check("t6_en_low_level", 32'(fifo_level), 32'd0);
        check("t6_en_low_vd", 32'(left_vd), 32'h0);
        check("t6_en_low_dac", 32'(leftdac), 32'h0);
        en = 1'b1;
        tick();

        // Randomized traffic
        rcnt = 0;
        for (int i = 0; i < 4000; i++) begin
            s_valid = ($urandom_range(0, ((i / 500) % 2 != 0) ? 6 : 40) == 0);
            s_left  = 16'($urandom);
            s_right = 16'($urandom);
            underrun_clr = ($urandom_range(0, 60) == 0);
            if (i % 900 == 400) en = 1'b0;
            else if (i % 900 == 420) en = 1'b1;
            if (i % 1300 == 700) rst = 1'b1;
            else if (i % 1300 == 702) rst = 1'b0;
            if (rst) begin
                ready = 1'b0;
            end else if (rcnt == 0) begin
                if (ready) begin
                    set_ready(1'b0);
                    rcnt = int'($urandom_range(1, 25));
                end else begin
                    set_ready(1'b1);
                    rcnt = int'($urandom_range(1, 4));
                end
            end else begin
                rcnt--;
            end
            tick();
        end
        s_valid = 1'b0;
        underrun_clr = 1'b0;
        set_ready(1'b0);
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
